// File: rtl/mips_bus_mem_responder.sv
// Bus-responder end of the mips_cpu_bus memory interface: two word RAM regions (stack, program),
// byte-enabled writes, waitrequest stalls of fixed or LFSR-chosen length, sticky error flag.
module mips_bus_mem_responder #(
    parameter string       PROG_INIT_FILE = "",
    parameter int          MEM_WORDS      = 4096,
    parameter logic [31:0] PROG_BASE      = 32'hBFC0_0000,
    parameter int          RANDOM_WAIT    = 0,
    parameter int          WAIT_CYCLES    = 2,
    parameter int          MAX_WAIT       = 3,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        bus_error
);

    localparam int          W_MAX = (RANDOM_WAIT != 0) ? MAX_WAIT : WAIT_CYCLES;
    localparam int          CNT_W = (W_MAX < 1) ? 1 : $clog2(W_MAX + 1);
    localparam int          IDX_W = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN  = 32'(MEM_WORDS * 4);
    localparam logic [15:0] MOD   = 16'(MAX_WAIT + 1);

    // Galois form of x^16+x^14+x^13+x^11+1; a non-zero state never reaches zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [CNT_W-1:0] pick_wait(input logic [15:0] s);
        return CNT_W'(s % MOD);
    endfunction

    logic [31:0]      stack_mem [MEM_WORDS];
    logic [31:0]      prog_mem  [MEM_WORDS];

    logic             req, accept, aligned, is_stack, is_prog, mapped, conflict;
    logic [31:0]      offset, rd_word;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] wait_cnt, wait_target, rand_target;
    logic [15:0]      lfsr;

    assign req         = read | write;
    assign wait_target = (RANDOM_WAIT != 0) ? rand_target : CNT_W'(WAIT_CYCLES);
    assign waitrequest = reset | (req & (wait_cnt != wait_target));
    assign accept      = req & ~waitrequest;

    // Address decode; misaligned addresses are handled as unmapped.
    assign offset   = address - PROG_BASE;
    assign aligned  = (address[1:0] == 2'b00);
    assign is_stack = (address < SPAN);
    assign is_prog  = (address >= PROG_BASE) && (offset < SPAN);
    assign mapped   = aligned & (is_stack | is_prog);
    assign conflict = read & write;
    assign idx      = address[IDX_W+1:2];
    assign rd_word  = is_stack ? stack_mem[idx] : prog_mem[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= '0;
            lfsr        <= LFSR_SEED;
            rand_target <= pick_wait(LFSR_SEED);
            readdata    <= 32'h0;
            bus_error   <= 1'b0;
        end else begin
            if (accept || !req) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (accept) begin
                lfsr        <= lfsr_step(lfsr);
                rand_target <= pick_wait(lfsr_step(lfsr));
            end
            if (accept && read) begin
                readdata <= (mapped && !conflict) ? rd_word : 32'h0;
            end
            if (accept && (conflict || !mapped)) begin
                bus_error <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset so program contents survive it.
    always_ff @(posedge clk) begin
        if (accept && write && !read && mapped) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    if (is_stack) begin
                        stack_mem[idx][8*i +: 8] <= writedata[8*i +: 8];
                    end else begin
                        prog_mem[idx][8*i +: 8] <= writedata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_bus_mem_responder.sv
// Scoreboard bench for mips_bus_mem_responder: three instances (zero wait, three waits, random).
module tb_mips_bus_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset [3];
    logic        read [3];
    logic        write [3];
    logic [31:0] address [3];
    logic [31:0] writedata [3];
    logic [3:0]  byteenable [3];
    logic        waitrequest [3];
    logic [31:0] readdata [3];
    logic        bus_error [3];

    mips_bus_mem_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset[0]), .address(address[0]), .read(read[0]), .write(write[0]),
        .writedata(writedata[0]), .byteenable(byteenable[0]), .waitrequest(waitrequest[0]),
        .readdata(readdata[0]), .bus_error(bus_error[0]));

    mips_bus_mem_responder #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset[1]), .address(address[1]), .read(read[1]), .write(write[1]),
        .writedata(writedata[1]), .byteenable(byteenable[1]), .waitrequest(waitrequest[1]),
        .readdata(readdata[1]), .bus_error(bus_error[1]));

    mips_bus_mem_responder #(.RANDOM_WAIT(1), .MAX_WAIT(3), .LFSR_SEED(16'hACE1)) u_rnd (
        .clk(clk), .reset(reset[2]), .address(address[2]), .read(read[2]), .write(write[2]),
        .writedata(writedata[2]), .byteenable(byteenable[2]), .waitrequest(waitrequest[2]),
        .readdata(readdata[2]), .bus_error(bus_error[2]));

    typedef struct {
        int          k;
        logic [31:0] data;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic pend [3] = '{1'b0, 1'b0, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: readdata is due on the cycle after each read acceptance.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (pend[k]) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("unexpected_read_u%0d", k), readdata[k], 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s_inst", e.tag), 32'(k), 32'(e.k));
                    check(e.tag, readdata[k], e.data);
                end
            end
            pend[k] <= read[k] && !waitrequest[k] && !reset[k];
        end
    end

    // Called just after a rising edge; returns just after the acceptance edge.
    task automatic xfer(input int k, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp,
                        input string tag, output int stalls);
        bit done;
        exp_t e;
        if (rd) begin
            e.k = k; e.data = exp; e.tag = tag;
            exp_q.push_back(e);
        end
        read[k] = rd; write[k] = wr; address[k] = a; writedata[k] = wd; byteenable[k] = be;
        stalls = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!waitrequest[k]) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 40) begin
                    check({tag, "_timeout"}, 32'(stalls), 32'd40);
                    if (rd) void'(exp_q.pop_back());
                    done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        read[k] = 1'b0; write[k] = 1'b0;
    endtask

    task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input int exp_stalls, input string tag);
        int s;
        xfer(k, 1'b0, 1'b1, a, d, be, 32'h0, tag, s);
        if (exp_stalls >= 0) check({tag, "_stalls"}, 32'(s), 32'(exp_stalls));
    endtask

    task automatic rd(input int k, input logic [31:0] a, input logic [31:0] exp,
                      input int exp_stalls, input string tag);
        int s;
        xfer(k, 1'b1, 1'b0, a, 32'h0, 4'h0, exp, tag, s);
        if (exp_stalls >= 0) check({tag, "_stalls"}, 32'(s), 32'(exp_stalls));
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          s;
        logic [15:0] lfsr;
        int          tgt;
        bit          seen [4];

        for (int k = 0; k < 3; k++) begin
            reset[k] = 1'b1; read[k] = 1'b0; write[k] = 1'b0;
            address[k] = 32'h0; writedata[k] = 32'h0; byteenable[k] = 4'h0;
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_waitreq_u%0d", k), 32'(waitrequest[k]), 32'd1);
            check($sformatf("rst_readdata_u%0d", k), readdata[k], 32'h0);
            check($sformatf("rst_bus_error_u%0d", k), 32'(bus_error[k]), 32'd0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) reset[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("idle_waitreq_u%0d", k), 32'(waitrequest[k]), 32'd0);
        @(posedge clk); #1;

        // Zero-wait instance: basic write/read, byte lanes, region edges.
        wr(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, "t1_wr");
        rd(0, 32'h10, 32'hDEADBEEF, 0, "t1_rd");
        wr(0, 32'h20, 32'h11223344, 4'hF, 0, "t3_wr_full");
        wr(0, 32'h20, 32'hAABBCCDD, 4'b0101, 0, "t3_wr_lanes");
        rd(0, 32'h20, 32'h11BB33DD, 0, "t3_rd_lanes");
        wr(0, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, "t3_wr_none");
        rd(0, 32'h20, 32'h11BB33DD, 0, "t3_rd_none");
        wr(0, 32'h3FFC, 32'hCAFEF00D, 4'hF, 0, "stack_top_wr");
        rd(0, 32'h3FFC, 32'hCAFEF00D, 0, "stack_top_rd");
        wr(0, 32'hBFC0_3FFC, 32'h0123ABCD, 4'hF, 0, "prog_top_wr");
        rd(0, 32'hBFC0_3FFC, 32'h0123ABCD, 0, "prog_top_rd");
        rd(0, 32'h3FFC, 32'hCAFEF00D, 0, "stack_top_rd2");
        @(negedge clk);
        check("no_error_yet", 32'(bus_error[0]), 32'd0);
        @(posedge clk); #1;

        // Error cases on the zero-wait instance.
        rd(0, 32'h8000_0000, 32'h0, 0, "t4_unmapped_rd");
        @(negedge clk);
        check("t4_bus_error_set", 32'(bus_error[0]), 32'd1);
        @(posedge clk); #1;
        rd(0, 32'h10, 32'hDEADBEEF, 0, "t4_valid_rd");
        rd(0, 32'h4000, 32'h0, 0, "stack_end_rd");
        rd(0, 32'h12, 32'h0, 0, "misaligned_rd");
        wr(0, 32'h11, 32'h0, 4'hF, 0, "misaligned_wr");
        xfer(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF, 32'h0, "rdwr_conflict", s);
        rd(0, 32'h10, 32'hDEADBEEF, 0, "t4_word_intact");
        @(negedge clk);
        check("t4_bus_error_sticky", 32'(bus_error[0]), 32'd1);
        @(posedge clk); #1;

        // Three-wait instance: program region with stalls.
        wr(1, 32'hBFC0_0000, 32'h24020005, 4'hF, 3, "t2_wr");
        rd(1, 32'hBFC0_0000, 32'h24020005, 3, "t2_rd");
        @(negedge clk);
        check("t2_bus_error", 32'(bus_error[1]), 32'd0);
        @(posedge clk); #1;

        // Reset during a stalled write.
        wr(1, 32'h40, 32'h12345678, 4'hF, 3, "t5_pre_wr");
        read[1] = 1'b0; write[1] = 1'b1; address[1] = 32'h40;
        writedata[1] = 32'h5; byteenable[1] = 4'hF;
        @(negedge clk);
        check("t5_stall1", 32'(waitrequest[1]), 32'd1);
        @(posedge clk); #1;
        reset[1] = 1'b1; write[1] = 1'b0;
        @(negedge clk);
        check("t5_waitreq_in_reset", 32'(waitrequest[1]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_readdata_reset", readdata[1], 32'h0);
        check("t5_waitreq_in_reset2", 32'(waitrequest[1]), 32'd1);
        @(posedge clk); #1;
        reset[1] = 1'b0;
        rd(1, 32'h40, 32'h12345678, 3, "t5_word_unchanged");
        rd(1, 32'hBFC0_0000, 32'h24020005, 3, "t5_prog_kept");

        // Random-wait instance: stall lengths follow the LFSR sequence.
        lfsr = 16'hACE1;
        tgt  = int'(lfsr % 16'd4);
        for (int i = 0; i < 4; i++) seen[i] = 1'b0;
        wr(2, 32'h10, 32'h0BADF00D, 4'hF, tgt, "t6_wr");
        for (int i = 0; i < 1001; i++) begin
            lfsr = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            tgt  = int'(lfsr % 16'd4);
            seen[tgt] = 1'b1;
            if (i == 1000) break;
            rd(2, 32'h10, 32'h0BADF00D, tgt, $sformatf("t6_rd%0d", i));
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("t6_seen_stall%0d", i), 32'(seen[i]), 32'd1);

        next_cycle();
        next_cycle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
